pe_array_feeder: RTL and testbench
==================================

// Module: pe_array_feeder
// PURPOSE
//  Edge driver for the ROWS x COLS weight-stationary PE grid.
//  - Buffers one weight tile, then shifts it down every column in store mode (PE_mode=1).
//  - Streams activation vectors into the row inputs (data_left) with diagonal skew.
//  - Acts as the transmitter side of the PE up/left interface; bottom-edge psum collection is outside this block.
// PARAMETERS
//  ROWS   4   PE rows; activation lanes; weight beats per tile
//  COLS   4   PE columns; weight lanes per beat
//  KW     16  width of k_len and the feed counter
// PORTS
//  PE_clk         in   1        clock
//  PE_rst_n       in   1        async active-low reset
//  start          in   1        begin tile; sampled in IDLE only
//  k_len          in   KW       number of activation vectors; latched on start
//  w_valid        in   1        weight beat valid
//  w_ready        out  1        weight beat accept
//  w_data         in   COLS*9   int9 per column; beat b = weights for PE row b
//  act_valid      in   1        activation vector valid
//  act_ready      out  1        activation accept
//  act_data       in   ROWS*9   int9 per row, lane r -> PE row r
//  busy           out  1        FSM not IDLE
//  done           out  1        1-cycle pulse at tile end
//  PE_mode        out  1        global store-mode select to grid
//  col_en_up      out  COLS     en_up into top PE of each column
//  col_data_up    out  COLS*32  int32 into top PE (sign-ext weight / 0)
//  row_en_left    out  ROWS     en_left into column-0 PE of each row
//  row_data_left  out  ROWS*9   int9 activation into column-0 PE
// BEHAVIOUR
//  Reset:
//   - All outputs 0; FSM in IDLE; counters and skew lines cleared.
//   - Weight buffer contents are don't-care.
//  FSM: IDLE -> LOAD_BUF -> PUSH -> FEED -> DRAIN -> DONE -> IDLE.
//  IDLE:
//   - On start, latch k_len and go to LOAD_BUF.
//  LOAD_BUF:
//   - w_ready=1.
//   - Each w_valid&w_ready beat b (0..ROWS-1) is stored in wbuf[b].
//   - Gaps in w_valid are allowed.
//   - After beat ROWS-1, go to PUSH.
//  PUSH:
//   - Lasts exactly ROWS consecutive cycles j=0..ROWS-1, with no gaps.
//   - PE_mode=1 and col_en_up all 1.
//   - col_data_up[c] = sext32(wbuf[ROWS-1-j][c]).
//   - Result: PE row r holds wbuf[r] once PE_mode drops.
//   - PE_mode=0 from the first cycle after PUSH.
//  FEED:
//   - PE_mode=0; col_en_up=0; col_data_up=0.
//   - act_ready=1; count accepted vectors.
//   - After the k_len-th accept, go to DRAIN.
//   - If k_len==0, skip FEED and go straight to DRAIN.
//  Skew:
//   - Lane r passes through an r-stage register line, so row r sees vector n exactly r cycles after row 0.
//   - Row 0 is registered once: row_en_left[0]/row_data_left[0] appear the cycle after the accept.
//   - A no-accept cycle injects en=0, and the bubble propagates down the skew like data.
//   - row_data_left holds its last value while en=0.
//  DRAIN:
//   - Lasts exactly ROWS+COLS cycles, then DONE.
//   - The skew lines keep shifting during DRAIN.
//  DONE:
//   - done=1 for one cycle, then IDLE.
//  Invariants:
//   - PE_mode=1 never coincides with any row_en_left=1.
//   - act_ready=0 outside FEED; w_ready=0 outside LOAD_BUF.
//  Other rules:
//   - start while busy is ignored.
//   - Async reset mid-tile aborts to IDLE immediately with outputs 0; grid weights are not cleared.
//   - Counter wrap is impossible: the counter is compared against the latched k_len.
// STRUCTURE
//  Shared package pe_pkg:
//   - int9_t, int32_t typedefs.
//   - feeder_state_e enum.
//   - function sext9to32.
//  Sub-module: pe_skew_line #(DEPTH, W)
//   - en+data shift line; DEPTH=0 means pass-through.
//   - Instantiated once per row with DEPTH=r.
// TESTING
//  1 Weight order:
//   - Stimulus: ROWS=COLS=2; beats {1,2},{3,4}.
//   - col_data_up[0] must be 3 then 1; col_data_up[1] must be 4 then 2.
//   - PE_mode high exactly 2 cycles.
//  2 Sign extension:
//   - Stimulus: weight 9'h1FF.
//   - col_data_up must equal 32'hFFFFFFFF.
//  3 Weight stall:
//   - Stimulus: w_valid low 3 cycles between beats.
//   - PUSH must still run ROWS contiguous cycles.
//  4 Skew:
//   - Stimulus: act {5,6} accepted at cycle t.
//   - row0 must show 5 at t+1 and row1 must show 6 at t+2.
//   - Then assert act_valid low 1 cycle: a matching bubble must appear at row0 then row1.
//  5 Empty tile:
//   - Stimulus: k_len=0.
//   - act_ready must never assert.
//   - done must pulse exactly ROWS+COLS cycles after PUSH ends.
//  6 Reset mid-PUSH:
//   - PE_mode, col_en_up and busy must read 0 at once.
//   - The next start must reload the full tile.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE array edge logic.
package pe_pkg;
  typedef logic signed [8:0]  int9_t;
  typedef logic signed [31:0] int32_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_BUF,
    S_PUSH,
    S_FEED,
    S_DRAIN,
    S_DONE
  } feeder_state_e;

  function automatic int32_t sext9to32(input int9_t v);
    return {{23{v[8]}}, v};
  endfunction
endpackage

// File: rtl/pe_skew_line.sv
// Enable+data delay line; data holds its value while an enable bubble passes through.
module pe_skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 9
) (
  input  logic         PE_clk,
  input  logic         PE_rst_n,
  input  logic         in_en,
  input  logic [W-1:0] in_data,
  output logic         out_en,
  output logic [W-1:0] out_data
);
  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = PE_clk & PE_rst_n;
    assign out_en   = in_en;
    assign out_data = in_data;
  end else begin : g_line
    logic [DEPTH-1:0] en_q;
    logic [W-1:0]     data_q [DEPTH];

    always_ff @(posedge PE_clk or negedge PE_rst_n) begin
      if (!PE_rst_n) begin
        en_q <= '0;
        for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      end else begin
        en_q[0] <= in_en;
        if (in_en) data_q[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
          en_q[i] <= en_q[i-1];
          if (en_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end

    assign out_en   = en_q[DEPTH-1];
    assign out_data = data_q[DEPTH-1];
  end
endmodule

// File: rtl/pe_array_feeder.sv
// Edge feeder for the weight-stationary PE grid: buffers and pushes one weight tile,
// then streams diagonally skewed activation vectors into the row inputs.
//   state    | meaning
//   IDLE     | waiting for start
//   LOAD_BUF | accepting ROWS weight beats into wbuf
//   PUSH     | shifting wbuf down the columns, last beat first
//   FEED     | accepting k_len activation vectors
//   DRAIN    | ROWS+COLS cycles for the skew lines and grid to empty
//   DONE     | one-cycle done pulse
module pe_array_feeder
  import pe_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 16
) (
  input  logic              PE_clk,
  input  logic              PE_rst_n,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [COLS*9-1:0] w_data,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [ROWS*9-1:0] act_data,
  output logic              busy,
  output logic              done,
  output logic              PE_mode,
  output logic [COLS-1:0]   col_en_up,
  output logic [COLS*32-1:0] col_data_up,
  output logic [ROWS-1:0]   row_en_left,
  output logic [ROWS*9-1:0] row_data_left
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW = $clog2(ROWS + COLS);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(ROWS + COLS - 1);

  feeder_state_e     state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [KW-1:0]     feed_q, feed_d;
  logic [KW-1:0]     k_len_q, k_len_d;
  logic [COLS*9-1:0] wbuf [ROWS];
  logic [RW-1:0]     push_idx;
  logic              act_en_q;
  logic [ROWS*9-1:0] act_data_q;

  assign push_idx = ROW_LAST - row_q;
  assign busy     = (state_q != S_IDLE);

  always_ff @(posedge PE_clk or negedge PE_rst_n) begin
    if (!PE_rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      drain_q <= '0;
      feed_q  <= '0;
      k_len_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      drain_q <= drain_d;
      feed_q  <= feed_d;
      k_len_q <= k_len_d;
    end
  end

  always_ff @(posedge PE_clk) begin
    if (state_q == S_LOAD_BUF && w_valid) wbuf[row_q] <= w_data;
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    drain_d     = drain_q;
    feed_d      = feed_q;
    k_len_d     = k_len_q;
    w_ready     = 1'b0;
    act_ready   = 1'b0;
    PE_mode     = 1'b0;
    col_en_up   = '0;
    col_data_up = '0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_len_d = k_len;
          row_d   = '0;
          state_d = S_LOAD_BUF;
        end
      end
      S_LOAD_BUF: begin
        w_ready = 1'b1;
        if (w_valid) begin
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = S_PUSH;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      S_PUSH: begin
        PE_mode   = 1'b1;
        col_en_up = '1;
        for (int c = 0; c < COLS; c++)
          col_data_up[c*32 +: 32] = sext9to32(wbuf[push_idx][c*9 +: 9]);
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          feed_d  = '0;
          drain_d = '0;
          state_d = (k_len_q == '0) ? S_DRAIN : S_FEED;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      S_FEED: begin
        act_ready = 1'b1;
        if (act_valid) begin
          // k_len_q is nonzero here, so the subtraction cannot wrap
          if (feed_q == k_len_q - KW'(1)) begin
            drain_d = '0;
            state_d = S_DRAIN;
          end else begin
            feed_d = feed_q + KW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_DONE;
        else drain_d = drain_q + DW'(1);
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Injection register shared by all lanes; row r then adds r more stages.
  always_ff @(posedge PE_clk or negedge PE_rst_n) begin
    if (!PE_rst_n) begin
      act_en_q   <= 1'b0;
      act_data_q <= '0;
    end else begin
      act_en_q <= act_valid & act_ready;
      if (act_valid & act_ready) act_data_q <= act_data;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    pe_skew_line #(
      .DEPTH(r),
      .W    (9)
    ) u_skew (
      .PE_clk  (PE_clk),
      .PE_rst_n(PE_rst_n),
      .in_en   (act_en_q),
      .in_data (act_data_q[r*9 +: 9]),
      .out_en  (row_en_left[r]),
      .out_data(row_data_left[r*9 +: 9])
    );
  end
endmodule

// File: tb/tb_pe_array_feeder.sv
// Scoreboard bench for pe_array_feeder: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_pe_array_feeder;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KW   = 16;

  logic                PE_clk = 1'b0;
  logic                PE_rst_n = 1'b0;
  logic                start = 1'b0;
  logic [KW-1:0]       k_len = '0;
  logic                w_valid = 1'b0;
  logic                w_ready;
  logic [COLS*9-1:0]   w_data = '0;
  logic                act_valid = 1'b0;
  logic                act_ready;
  logic [ROWS*9-1:0]   act_data = '0;
  logic                busy;
  logic                done;
  logic                PE_mode;
  logic [COLS-1:0]     col_en_up;
  logic [COLS*32-1:0]  col_data_up;
  logic [ROWS-1:0]     row_en_left;
  logic [ROWS*9-1:0]   row_data_left;

  pe_array_feeder #(.ROWS(ROWS), .COLS(COLS), .KW(KW)) dut (
    .PE_clk       (PE_clk),
    .PE_rst_n     (PE_rst_n),
    .start        (start),
    .k_len        (k_len),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .act_valid    (act_valid),
    .act_ready    (act_ready),
    .act_data     (act_data),
    .busy         (busy),
    .done         (done),
    .PE_mode      (PE_mode),
    .col_en_up    (col_en_up),
    .col_data_up  (col_data_up),
    .row_en_left  (row_en_left),
    .row_data_left(row_data_left)
  );

  always #5 PE_clk = ~PE_clk;

  typedef struct { int cyc; logic [COLS*32-1:0] data; } push_exp_t;
  typedef struct { int cyc; logic [8:0] val; } row_exp_t;

  push_exp_t         q_push[$];
  row_exp_t          q_row[ROWS][$];
  int                q_done[$];
  logic [COLS*9-1:0] wfix [ROWS];
  logic [ROWS*9-1:0] act_fixed[$];
  logic [8:0]        last_val [ROWS];
  push_exp_t         mon_pe;
  row_exp_t          mon_re;
  int                cyc = 0;
  int                n_tests = 0;
  int                n_fail = 0;
  int                mode_run = 0;
  bit                k0_tile = 1'b0;

  always @(posedge PE_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge PE_clk);
    #1;
  endtask

  // Monitor: every negedge, pop expectations for whatever the DUT presents.
  always @(negedge PE_clk) begin
    if (!PE_rst_n) begin
      mode_run = 0;
      for (int r = 0; r < ROWS; r++) last_val[r] = '0;
    end else begin
      chk("mode_vs_row_en", 64'(PE_mode & (|row_en_left)), 64'(0));
      if (!busy) chk("act_ready_idle", 64'(act_ready), 64'(0));
      if (k0_tile) chk("act_ready_k0", 64'(act_ready), 64'(0));
      if (PE_mode) mode_run++;
      else if (mode_run != 0) begin
        chk("push_len", 64'(mode_run), 64'(ROWS));
        mode_run = 0;
      end
      if (PE_mode || (|col_en_up)) begin
        chk("push_mode", 64'(PE_mode), 64'(1));
        chk("push_col_en", 64'(col_en_up), 64'({COLS{1'b1}}));
        chk("push_expected", 64'(q_push.size() != 0), 64'(1));
        if (q_push.size() != 0) begin
          mon_pe = q_push.pop_front();
          chk("push_cycle", 64'(cyc), 64'(mon_pe.cyc));
          for (int c = 0; c < COLS; c++)
            chk($sformatf("col_data_up[%0d]", c), 64'(col_data_up[c*32 +: 32]), 64'(mon_pe.data[c*32 +: 32]));
        end
      end else begin
        chk("col_data_idle", 64'(|col_data_up), 64'(0));
      end
      for (int r = 0; r < ROWS; r++) begin
        if (row_en_left[r]) begin
          chk($sformatf("row%0d_expected", r), 64'(q_row[r].size() != 0), 64'(1));
          if (q_row[r].size() != 0) begin
            mon_re = q_row[r].pop_front();
            chk($sformatf("row%0d_cycle", r), 64'(cyc), 64'(mon_re.cyc));
            chk($sformatf("row%0d_data", r), 64'(row_data_left[r*9 +: 9]), 64'(mon_re.val));
            last_val[r] = mon_re.val;
          end
        end else begin
          chk($sformatf("row%0d_hold", r), 64'(row_data_left[r*9 +: 9]), 64'(last_val[r]));
        end
      end
      if (done) begin
        chk("done_expected", 64'(q_done.size() != 0), 64'(1));
        if (q_done.size() != 0) chk("done_cycle", 64'(cyc), 64'(q_done.pop_front()));
      end
    end
  end

  function automatic int sext9(input logic [8:0] x);
    int v;
    v = int'(x);
    if (v >= 256) v = v - 512;
    return v;
  endfunction

  task automatic run_tile(input int k, input int wgap, input int agap, input bit fixed_w,
                          input bit abort, input bit bad_start);
    int                tmo, g, w_edge, a_edge;
    logic [COLS*9-1:0] beat [ROWS];
    logic [ROWS*9-1:0] av;
    push_exp_t         pe;
    row_exp_t          re;
    tmo = 0;
    while (busy && tmo < 200) begin step(); tmo++; end
    chk("idle_before_start", 64'(busy), 64'(0));
    for (int b = 0; b < ROWS; b++)
      for (int c = 0; c < COLS; c++)
        beat[b][c*9 +: 9] = fixed_w ? wfix[b][c*9 +: 9] : 9'($urandom);
    k0_tile = (k == 0);
    k_len = KW'(k);
    start = 1'b1;
    step();
    start = 1'b0;
    k_len = KW'($urandom);
    w_edge = 0;
    for (int b = 0; b < ROWS; b++) begin
      w_valid = 1'b0;
      g = (wgap < 0) ? int'($urandom_range(0, 2)) : ((b == 0) ? 0 : wgap);
      repeat (g) step();
      w_valid = 1'b1;
      w_data = beat[b];
      tmo = 0;
      while (!w_ready && tmo < 20) begin step(); tmo++; end
      chk("w_ready_wait", 64'(w_ready), 64'(1));
      w_edge = cyc + 1;
      step();
    end
    w_valid = 1'b0;
    for (int j = 0; j < ROWS; j++) begin
      pe.cyc = w_edge + j;
      for (int c = 0; c < COLS; c++)
        pe.data[c*32 +: 32] = 32'(sext9(beat[ROWS-1-j][c*9 +: 9]));
      q_push.push_back(pe);
    end
    if (abort) begin
      step();
      #2;
      PE_rst_n = 1'b0;
      #1;
      chk("abort_pe_mode", 64'(PE_mode), 64'(0));
      chk("abort_col_en", 64'(col_en_up), 64'(0));
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_row_en", 64'(row_en_left), 64'(0));
      q_push.delete();
      k0_tile = 1'b0;
      step();
      PE_rst_n = 1'b1;
      step();
      return;
    end
    a_edge = w_edge;
    for (int n = 0; n < k; n++) begin
      act_valid = 1'b0;
      g = (agap < 0) ? int'($urandom_range(0, 2)) : agap;
      if (bad_start) start = 1'b1;
      repeat (g) step();
      start = 1'b0;
      if (act_fixed.size() != 0) av = act_fixed.pop_front();
      else for (int r = 0; r < ROWS; r++) av[r*9 +: 9] = 9'($urandom);
      act_valid = 1'b1;
      act_data = av;
      tmo = 0;
      while (!act_ready && tmo < 4*ROWS + 20) begin step(); tmo++; end
      chk("act_ready_wait", 64'(act_ready), 64'(1));
      a_edge = cyc + 1;
      for (int r = 0; r < ROWS; r++) begin
        re.cyc = a_edge + r;
        re.val = av[r*9 +: 9];
        q_row[r].push_back(re);
      end
      step();
    end
    act_valid = 1'b0;
    // DRAIN starts right after the last accept, or right after PUSH for an empty tile
    q_done.push_back((k == 0) ? (w_edge + ROWS + 1 + ROWS + COLS - 1) : (a_edge + ROWS + COLS));
    tmo = 0;
    while (busy && tmo < 4*(ROWS + COLS) + 20) begin step(); tmo++; end
    chk("tile_end_busy", 64'(busy), 64'(0));
    step();
    k0_tile = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_pe_mode", 64'(PE_mode), 64'(0));
    chk("rst_col_en", 64'(col_en_up), 64'(0));
    chk("rst_col_data", 64'(|col_data_up), 64'(0));
    chk("rst_row_en", 64'(row_en_left), 64'(0));
    chk("rst_row_data", 64'(|row_data_left), 64'(0));
    chk("rst_w_ready", 64'(w_ready), 64'(0));
    chk("rst_act_ready", 64'(act_ready), 64'(0));
    #10;
    PE_rst_n = 1'b1;
    step();

    wfix[0] = {9'd4, 9'd3, 9'd2, 9'd1};
    wfix[1] = {9'd8, 9'd7, 9'd6, 9'd5};
    wfix[2] = {9'h1FF, 9'h100, 9'h0FF, 9'h1FF};
    wfix[3] = {9'd16, 9'h1FE, 9'd0, 9'd13};
    act_fixed.push_back({9'd8, 9'd7, 9'd6, 9'd5});
    act_fixed.push_back({9'h1FF, 9'd11, 9'd10, 9'd9});
    act_fixed.push_back({9'd16, 9'd15, 9'd14, 9'd13});

    run_tile(3, 0, 1, 1'b1, 1'b0, 1'b0);
    run_tile(3, 3, -1, 1'b0, 1'b0, 1'b0);
    run_tile(0, -1, -1, 1'b0, 1'b0, 1'b0);
    run_tile(5, -1, 0, 1'b0, 1'b1, 1'b0);
    run_tile(4, -1, -1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      run_tile(int'($urandom_range(0, 9)), -1, -1, 1'b0, 1'b0, i[0]);

    repeat (3) step();
    chk("push_queue_empty", 64'(q_push.size()), 64'(0));
    chk("done_queue_empty", 64'(q_done.size()), 64'(0));
    for (int r = 0; r < ROWS; r++)
      chk($sformatf("row%0d_queue_empty", r), 64'(q_row[r].size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
